// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, framing constants
// and the baud divider calculation.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_e;

   localparam int OVERSAMPLE = 16;
   localparam int DATA_BITS  = 8;
   localparam int MID_SAMPLE = 7;

   // Clocks per oversample tick; integer truncation, caller keeps the result >= 1.
   function automatic int calc_div(input int clk_hz, input int baud);
      return clk_hz / (baud * OVERSAMPLE);
   endfunction

endpackage

// File: rtl/rx_oversample_tick.sv
// Oversample tick generator: divides clk down to 16x the baud rate.
// The tick is registered, so it is high in the cycle after the counter
// reaches DIV-1; a clear holds both the counter and the tick at zero.
module rx_oversample_tick
   import uart_pkg::*;
#(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic arst_n,
   input  logic clr_i,
   output logic tick_o
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic          tick_q;

   // Free-running 0..DIV-1 counter while enabled, held at zero while cleared.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else if (clr_i) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         tick_q <= (cnt_q == LAST);
         cnt_q  <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      end
   end

   assign tick_o = tick_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first. Synchronizes the line, detects a falling
// edge, checks the start bit at mid-bit, samples each data bit at mid-bit and
// presents good bytes with a one-cycle valid; bad stop bits raise frame_err.
module uart_rx
   import uart_pkg::*;
#(
   parameter int UART_INPUT_CLK = 100_000_000,
   parameter int baud_rate      = 9600
) (
   input  logic       clk,
   input  logic       arst_n,
   input  logic       rx_en,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int DIV = calc_div(UART_INPUT_CLK, baud_rate);
   localparam int SW  = $clog2(OVERSAMPLE);
   localparam int BW  = $clog2(DATA_BITS);

   localparam logic [SW-1:0] SAMP_MID  = SW'(MID_SAMPLE);
   localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   logic                 sync1_q, rx_s_q, rx_prev_q;
   state_e               state_q;
   logic [SW-1:0]        samp_q;
   logic [BW-1:0]        bit_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [7:0]           data_q;
   logic                 valid_q, ferr_q, busy_q;
   logic                 tick;
   logic                 tick_clr;

   // The divider only runs inside a frame, so every frame starts phase-aligned.
   assign tick_clr = (state_q == IDLE);

   rx_oversample_tick #(
      .DIV (DIV)
   ) u_tick (
      .clk    (clk),
      .arst_n (arst_n),
      .clr_i  (tick_clr),
      .tick_o (tick)
   );

   // Two-flop synchronizer plus one-cycle delay for falling-edge detection; idle-high reset.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         sync1_q   <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         sync1_q   <= rx;
         rx_s_q    <= sync1_q;
         rx_prev_q <= rx_s_q;
      end
   end

   // Receive FSM with registered outputs; valid and frame_err default low each cycle.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= IDLE;
         samp_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               // A fresh falling edge is required, so a held-low line cannot retrigger.
               if (rx_en && !rx_s_q && rx_prev_q) begin
                  state_q <= START;
                  samp_q  <= '0;
                  bit_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            START: begin
               if (tick) begin
                  if (samp_q == SAMP_MID) begin
                     samp_q <= '0;
                     if (!rx_s_q) begin
                        state_q <= DATA;
                     end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                     end
                  end else begin
                     samp_q <= samp_q + SW'(1);
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  samp_q <= samp_q + SW'(1);
                  if (samp_q == SAMP_LAST) begin
                     shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
                     bit_q   <= bit_q + BW'(1);
                     if (bit_q == BIT_LAST) begin
                        state_q <= STOP;
                     end
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  samp_q <= samp_q + SW'(1);
                  if (samp_q == SAMP_LAST) begin
                     if (rx_s_q) begin
                        data_q  <= shift_q;
                        valid_q <= 1'b1;
                     end else begin
                        ferr_q <= 1'b1;
                     end
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign data_out  = data_q;
   assign valid     = valid_q;
   assign frame_err = ferr_q;
   assign busy      = busy_q;

endmodule
